// File: rtl/dcache_top.sv
// Data-cache stage: direct-mapped write-back cache between the ALU and write-back stages,
// with a single-outstanding, line-wide memory port used for evictions and refills.
package dcache_pkg;
    localparam int REG_FILE_ADDR_WIDTH = 5;
    localparam int REG_FILE_DATA_WIDTH = 32;
    localparam int PC_WIDTH            = 32;

    typedef enum logic {
        SIZE_BYTE = 1'b0,
        SIZE_WORD = 1'b1
    } mem_size_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        mem_size_t   size;
        logic        is_store;
    } dcache_request_t;
endpackage

module dcache_top
    import dcache_pkg::*;
#(
    parameter int DC_LINES     = 4,
    parameter int DC_LINE_BITS = 128
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           req_dcache_valid,
    input  dcache_request_t                req_dcache_info,
    input  logic                           req_m_type_instr,
    input  logic                           req_r_type_instr,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] req_dst_reg,
    input  logic [PC_WIDTH-1:0]            req_dcache_pc,
    output logic                           stall_alu,
    output logic [REG_FILE_DATA_WIDTH-1:0] cache_data_bypass,
    output logic                           cache_data_bp_valid,
    output logic                           req_mm_valid,
    output logic [31:0]                    req_mm_addr,
    output logic                           req_mm_is_store,
    output logic [DC_LINE_BITS-1:0]        req_mm_data,
    input  logic                           rsp_mm_valid,
    input  logic [DC_LINE_BITS-1:0]        rsp_mm_data,
    output logic                           req_wb_valid,
    output logic [31:0]                    req_wb_data,
    output logic [REG_FILE_ADDR_WIDTH-1:0] req_wb_addr,
    output logic [PC_WIDTH-1:0]            req_wb_pc,
    output logic                           req_wb_rf_write,
    output logic                           xcpt_dcache_valid,
    output logic [31:0]                    xcpt_dcache_addr
);

    localparam int OFFSET_BITS = $clog2(DC_LINE_BITS / 8);
    localparam int INDEX_BITS  = $clog2(DC_LINES);
    localparam int TAG_BITS    = 32 - OFFSET_BITS - INDEX_BITS;
    localparam int SEL_BITS    = OFFSET_BITS + 3;

    typedef enum logic [1:0] {IDLE, EVICT, REFILL, RESPOND} state_t;

    function automatic logic [31:0] line_read(input logic [DC_LINE_BITS-1:0] line,
                                              input logic [OFFSET_BITS-1:0]  off,
                                              input mem_size_t               size);
        logic [SEL_BITS-1:0] word_sel;
        logic [SEL_BITS-1:0] byte_sel;
        word_sel = {off[OFFSET_BITS-1:2], 5'b0};
        byte_sel = {off, 3'b0};
        if (size == SIZE_WORD) return line[word_sel +: 32];
        return {24'b0, line[byte_sel +: 8]};
    endfunction

    function automatic logic [DC_LINE_BITS-1:0] line_write(input logic [DC_LINE_BITS-1:0] line,
                                                           input logic [OFFSET_BITS-1:0]  off,
                                                           input mem_size_t               size,
                                                           input logic [31:0]             data);
        logic [DC_LINE_BITS-1:0] merged;
        logic [SEL_BITS-1:0]     word_sel;
        logic [SEL_BITS-1:0]     byte_sel;
        merged   = line;
        word_sel = {off[OFFSET_BITS-1:2], 5'b0};
        byte_sel = {off, 3'b0};
        if (size == SIZE_WORD) merged[word_sel +: 32] = data;
        else                   merged[byte_sel +: 8]  = data[7:0];
        return merged;
    endfunction

    state_t                           state_q, state_d;
    logic [DC_LINES-1:0]              valid_q, valid_d;
    logic [DC_LINES-1:0]              dirty_q, dirty_d;
    logic [TAG_BITS-1:0]              tag_q [DC_LINES];
    logic [TAG_BITS-1:0]              tag_d [DC_LINES];
    logic [DC_LINE_BITS-1:0]          data_q [DC_LINES];
    logic [DC_LINE_BITS-1:0]          data_d [DC_LINES];
    dcache_request_t                  lreq_q, lreq_d;
    logic [REG_FILE_ADDR_WIDTH-1:0]   ldst_q, ldst_d;
    logic [PC_WIDTH-1:0]              lpc_q, lpc_d;
    logic                             mm_valid_q, mm_valid_d;
    logic [31:0]                      mm_addr_q, mm_addr_d;
    logic                             mm_is_store_q, mm_is_store_d;
    logic [DC_LINE_BITS-1:0]          mm_data_q, mm_data_d;
    logic                             wb_valid_q, wb_valid_d;
    logic [31:0]                      wb_data_q, wb_data_d;
    logic [REG_FILE_ADDR_WIDTH-1:0]   wb_addr_q, wb_addr_d;
    logic [PC_WIDTH-1:0]              wb_pc_q, wb_pc_d;
    logic                             wb_rf_write_q, wb_rf_write_d;
    logic                             xcpt_valid_q, xcpt_valid_d;
    logic [31:0]                      xcpt_addr_q, xcpt_addr_d;

    dcache_request_t       req, exec_req;
    logic [INDEX_BITS-1:0] req_idx, exec_idx, l_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic                  req_hit, req_misaligned, accept_miss, do_access;

    assign req            = req_dcache_info;
    assign req_idx        = req.addr[OFFSET_BITS +: INDEX_BITS];
    assign req_tag        = req.addr[31 -: TAG_BITS];
    assign l_idx          = lreq_q.addr[OFFSET_BITS +: INDEX_BITS];
    assign req_misaligned = (req.size == SIZE_WORD) && (req.addr[1:0] != 2'b00);
    assign req_hit        = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign accept_miss    = (state_q == IDLE) && req_dcache_valid && req_m_type_instr
                            && !req_misaligned && !req_hit;
    // A hit in IDLE and the replay in RESPOND share one access path.
    assign exec_req       = (state_q == RESPOND) ? lreq_q : req;
    assign exec_idx       = exec_req.addr[OFFSET_BITS +: INDEX_BITS];

    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        dirty_d       = dirty_q;
        tag_d         = tag_q;
        data_d        = data_q;
        lreq_d        = lreq_q;
        ldst_d        = ldst_q;
        lpc_d         = lpc_q;
        mm_valid_d    = mm_valid_q;
        mm_addr_d     = mm_addr_q;
        mm_is_store_d = mm_is_store_q;
        mm_data_d     = mm_data_q;
        wb_valid_d    = 1'b0;
        wb_rf_write_d = 1'b0;
        wb_data_d     = wb_data_q;
        wb_addr_d     = wb_addr_q;
        wb_pc_d       = wb_pc_q;
        xcpt_valid_d  = 1'b0;
        xcpt_addr_d   = xcpt_addr_q;
        do_access     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_dcache_valid) begin
                    wb_valid_d = 1'b1;
                    wb_addr_d  = req_dst_reg;
                    wb_pc_d    = req_dcache_pc;
                    wb_data_d  = req.data;
                    if (req_m_type_instr) begin
                        if (req_misaligned) begin
                            xcpt_valid_d = 1'b1;
                            xcpt_addr_d  = req.addr;
                            wb_data_d    = '0;
                        end else if (req_hit) begin
                            do_access = 1'b1;
                        end else begin
                            wb_valid_d = 1'b0;
                            lreq_d     = req;
                            ldst_d     = req_dst_reg;
                            lpc_d      = req_dcache_pc;
                            mm_valid_d = 1'b1;
                            if (valid_q[req_idx] && dirty_q[req_idx]) begin
                                state_d       = EVICT;
                                mm_is_store_d = 1'b1;
                                mm_addr_d     = {tag_q[req_idx], req_idx, {OFFSET_BITS{1'b0}}};
                                mm_data_d     = data_q[req_idx];
                            end else begin
                                state_d       = REFILL;
                                mm_is_store_d = 1'b0;
                                mm_addr_d     = {req_tag, req_idx, {OFFSET_BITS{1'b0}}};
                                mm_data_d     = '0;
                            end
                        end
                    end else begin
                        wb_rf_write_d = req_r_type_instr;
                    end
                end
            end
            EVICT: begin
                if (rsp_mm_valid) begin
                    state_d       = REFILL;
                    mm_is_store_d = 1'b0;
                    mm_addr_d     = {lreq_q.addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                    mm_data_d     = '0;
                end
            end
            REFILL: begin
                if (rsp_mm_valid) begin
                    data_d[l_idx]  = rsp_mm_data;
                    tag_d[l_idx]   = lreq_q.addr[31 -: TAG_BITS];
                    valid_d[l_idx] = 1'b1;
                    dirty_d[l_idx] = 1'b0;
                    mm_valid_d     = 1'b0;
                    state_d        = RESPOND;
                end
            end
            RESPOND: begin
                do_access  = 1'b1;
                wb_valid_d = 1'b1;
                wb_addr_d  = ldst_q;
                wb_pc_d    = lpc_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (do_access) begin
            if (exec_req.is_store) begin
                data_d[exec_idx]  = line_write(data_q[exec_idx], exec_req.addr[OFFSET_BITS-1:0],
                                               exec_req.size, exec_req.data);
                dirty_d[exec_idx] = 1'b1;
                wb_data_d         = exec_req.data;
            end else begin
                wb_data_d     = line_read(data_q[exec_idx], exec_req.addr[OFFSET_BITS-1:0],
                                          exec_req.size);
                wb_rf_write_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            valid_q       <= '0;
            dirty_q       <= '0;
            tag_q         <= '{default: '0};
            data_q        <= '{default: '0};
            lreq_q        <= '0;
            ldst_q        <= '0;
            lpc_q         <= '0;
            mm_valid_q    <= 1'b0;
            mm_addr_q     <= '0;
            mm_is_store_q <= 1'b0;
            mm_data_q     <= '0;
            wb_valid_q    <= 1'b0;
            wb_data_q     <= '0;
            wb_addr_q     <= '0;
            wb_pc_q       <= '0;
            wb_rf_write_q <= 1'b0;
            xcpt_valid_q  <= 1'b0;
            xcpt_addr_q   <= '0;
        end else begin
            state_q       <= state_d;
            valid_q       <= valid_d;
            dirty_q       <= dirty_d;
            tag_q         <= tag_d;
            data_q        <= data_d;
            lreq_q        <= lreq_d;
            ldst_q        <= ldst_d;
            lpc_q         <= lpc_d;
            mm_valid_q    <= mm_valid_d;
            mm_addr_q     <= mm_addr_d;
            mm_is_store_q <= mm_is_store_d;
            mm_data_q     <= mm_data_d;
            wb_valid_q    <= wb_valid_d;
            wb_data_q     <= wb_data_d;
            wb_addr_q     <= wb_addr_d;
            wb_pc_q       <= wb_pc_d;
            wb_rf_write_q <= wb_rf_write_d;
            xcpt_valid_q  <= xcpt_valid_d;
            xcpt_addr_q   <= xcpt_addr_d;
        end
    end

    assign stall_alu           = (state_q != IDLE) || accept_miss;
    assign req_mm_valid        = mm_valid_q;
    assign req_mm_addr         = mm_addr_q;
    assign req_mm_is_store     = mm_is_store_q;
    assign req_mm_data         = mm_data_q;
    assign req_wb_valid        = wb_valid_q;
    assign req_wb_data         = wb_data_q;
    assign req_wb_addr         = wb_addr_q;
    assign req_wb_pc           = wb_pc_q;
    assign req_wb_rf_write     = wb_rf_write_q;
    assign cache_data_bypass   = wb_data_q;
    assign cache_data_bp_valid = wb_valid_q && wb_rf_write_q;
    assign xcpt_dcache_valid   = xcpt_valid_q;
    assign xcpt_dcache_addr    = xcpt_addr_q;

endmodule

// File: tb/tb_dcache_top.sv
// Self-checking bench for dcache_top: expected write-backs are queued at issue time and
// popped by a monitor; each scenario task checks its own stall/memory/exception timing.
module tb_dcache_top;
    import dcache_pkg::*;

    logic            clock = 1'b0;
    logic            reset;
    logic            req_dcache_valid;
    dcache_request_t req_dcache_info;
    logic            req_m_type_instr;
    logic            req_r_type_instr;
    logic [4:0]      req_dst_reg;
    logic [31:0]     req_dcache_pc;
    logic            stall_alu;
    logic [31:0]     cache_data_bypass;
    logic            cache_data_bp_valid;
    logic            req_mm_valid;
    logic [31:0]     req_mm_addr;
    logic            req_mm_is_store;
    logic [127:0]    req_mm_data;
    logic            rsp_mm_valid;
    logic [127:0]    rsp_mm_data;
    logic            req_wb_valid;
    logic [31:0]     req_wb_data;
    logic [4:0]      req_wb_addr;
    logic [31:0]     req_wb_pc;
    logic            req_wb_rf_write;
    logic            xcpt_dcache_valid;
    logic [31:0]     xcpt_dcache_addr;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
        logic [31:0] pc;
        logic        rf_write;
        logic        chk_data;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    wb_exp_t mon_exp;
    int      tests_run    = 0;
    int      tests_failed = 0;

    localparam logic [127:0] LINE_A = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
    localparam logic [127:0] LINE_A_MERGED = {32'h33333333, 32'h22222222, 32'h11111111, 32'h55ADBEEF};
    localparam logic [127:0] LINE_B = {32'h77777777, 32'h66666666, 32'h55555555, 32'hCAFEF00D};

    dcache_top dut (
        .clock               (clock),
        .reset               (reset),
        .req_dcache_valid    (req_dcache_valid),
        .req_dcache_info     (req_dcache_info),
        .req_m_type_instr    (req_m_type_instr),
        .req_r_type_instr    (req_r_type_instr),
        .req_dst_reg         (req_dst_reg),
        .req_dcache_pc       (req_dcache_pc),
        .stall_alu           (stall_alu),
        .cache_data_bypass   (cache_data_bypass),
        .cache_data_bp_valid (cache_data_bp_valid),
        .req_mm_valid        (req_mm_valid),
        .req_mm_addr         (req_mm_addr),
        .req_mm_is_store     (req_mm_is_store),
        .req_mm_data         (req_mm_data),
        .rsp_mm_valid        (rsp_mm_valid),
        .rsp_mm_data         (rsp_mm_data),
        .req_wb_valid        (req_wb_valid),
        .req_wb_data         (req_wb_data),
        .req_wb_addr         (req_wb_addr),
        .req_wb_pc           (req_wb_pc),
        .req_wb_rf_write     (req_wb_rf_write),
        .xcpt_dcache_valid   (xcpt_dcache_valid),
        .xcpt_dcache_addr    (xcpt_dcache_addr)
    );

    always #5 clock = ~clock;

    // Scoreboard: every write-back must match the oldest queued expectation.
    always @(negedge clock) begin
        if (!reset && req_wb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL wb_unexpected: got data %h addr %0d, required no write-back",
                         req_wb_data, req_wb_addr);
            end else begin
                mon_exp = exp_q.pop_front();
                tests_run++;
                if (req_wb_addr !== mon_exp.addr || req_wb_pc !== mon_exp.pc
                    || req_wb_rf_write !== mon_exp.rf_write) begin
                    tests_failed++;
                    $display("[TB] FAIL wb_fields: got addr %0d pc %h rf_write %b, required addr %0d pc %h rf_write %b",
                             req_wb_addr, req_wb_pc, req_wb_rf_write, mon_exp.addr, mon_exp.pc, mon_exp.rf_write);
                end
                tests_run++;
                if (cache_data_bp_valid !== mon_exp.rf_write) begin
                    tests_failed++;
                    $display("[TB] FAIL bp_valid: got %b, required %b", cache_data_bp_valid, mon_exp.rf_write);
                end
                if (mon_exp.chk_data) begin
                    tests_run++;
                    if (req_wb_data !== mon_exp.data || cache_data_bypass !== mon_exp.data) begin
                        tests_failed++;
                        $display("[TB] FAIL wb_data: got data %h bypass %h, required %h",
                                 req_wb_data, cache_data_bypass, mon_exp.data);
                    end
                end
            end
        end
    end

    task automatic issue(input logic m, input logic r, input logic st, input mem_size_t sz,
                         input logic [31:0] addr, input logic [31:0] data, input logic [4:0] dst,
                         input logic [31:0] pc, input logic [31:0] exp_data, input logic exp_rf,
                         input logic exp_chk);
        wb_exp_t e;
        req_dcache_valid         = 1'b1;
        req_m_type_instr         = m;
        req_r_type_instr         = r;
        req_dcache_info.addr     = addr;
        req_dcache_info.data     = data;
        req_dcache_info.size     = sz;
        req_dcache_info.is_store = st;
        req_dst_reg              = dst;
        req_dcache_pc            = pc;
        e.data     = exp_data;
        e.addr     = dst;
        e.pc       = pc;
        e.rf_write = exp_rf;
        e.chk_data = exp_chk;
        exp_q.push_back(e);
    endtask

    task automatic idle_req();
        req_dcache_valid = 1'b0;
        req_m_type_instr = 1'b0;
        req_r_type_instr = 1'b0;
    endtask

    // Memory side: wait (bounded) for a request, capture it, answer it for one cycle.
    task automatic mm_respond(input logic [127:0] line, output logic [31:0] addr,
                              output logic is_store, output logic [127:0] data,
                              output logic timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (req_mm_valid === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clock);
        end
        addr     = req_mm_addr;
        is_store = req_mm_is_store;
        data     = req_mm_data;
        if (!timed_out) begin
            rsp_mm_valid = 1'b1;
            rsp_mm_data  = line;
            @(negedge clock);
            rsp_mm_valid = 1'b0;
            rsp_mm_data  = '0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_req();
        req_dcache_info = '0;
        req_dst_reg     = '0;
        req_dcache_pc   = '0;
        rsp_mm_valid    = 1'b0;
        rsp_mm_data     = '0;
        repeat (3) @(negedge clock);
        tests_run++;
        if ({stall_alu, req_mm_valid, req_wb_valid, req_wb_rf_write, cache_data_bp_valid,
             xcpt_dcache_valid, req_mm_is_store} !== 7'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl: got %b, required 0000000", {stall_alu, req_mm_valid,
                     req_wb_valid, req_wb_rf_write, cache_data_bp_valid, xcpt_dcache_valid, req_mm_is_store});
        end
        tests_run++;
        if ({req_mm_addr, req_wb_data, req_wb_addr, req_wb_pc, xcpt_dcache_addr, cache_data_bypass} !== '0
            || req_mm_data !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_data: got mm_addr %h wb_data %h xcpt_addr %h mm_data %h, required 0",
                     req_mm_addr, req_wb_data, xcpt_dcache_addr, req_mm_data);
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_rtype_branch();
        issue(1'b0, 1'b1, 1'b0, SIZE_WORD, 32'h0, 32'h0000_002A, 5'd3, 32'h1000, 32'h2A, 1'b1, 1'b1);
        #1;
        tests_run++;
        if (stall_alu !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rtype_stall: got %b, required 0", stall_alu);
        end
        @(negedge clock);
        tests_run++;
        if (req_wb_valid !== 1'b1 || cache_data_bp_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL rtype_latency: got wb_valid %b bp_valid %b, required 1 1",
                     req_wb_valid, cache_data_bp_valid);
        end
        issue(1'b0, 1'b0, 1'b0, SIZE_WORD, 32'h0, 32'h1234, 5'd7, 32'h1004, 32'h0, 1'b0, 1'b0);
        @(negedge clock);
        idle_req();
        tests_run++;
        if (req_wb_valid !== 1'b1 || cache_data_bp_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL branch_wb: got wb_valid %b bp_valid %b, required 1 0",
                     req_wb_valid, cache_data_bp_valid);
        end
        @(negedge clock);
        tests_run++;
        if (req_wb_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL wb_pulse: got wb_valid %b, required 0", req_wb_valid);
        end
    endtask

    task automatic test_load_miss();
        logic [31:0]  a;
        logic         s;
        logic [127:0] d;
        logic         to;
        issue(1'b1, 1'b0, 1'b0, SIZE_WORD, 32'h100, 32'h0, 5'd4, 32'h2000, 32'hDEADBEEF, 1'b1, 1'b1);
        #1;
        tests_run++;
        if (stall_alu !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL miss_stall_accept: got %b, required 1", stall_alu);
        end
        @(negedge clock);
        idle_req();
        mm_respond(LINE_A, a, s, d, to);
        tests_run++;
        if (to !== 1'b0 || a !== 32'h100 || s !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL refill_req: got timeout %b addr %h is_store %b, required 0 00000100 0", to, a, s);
        end
        tests_run++;
        if (stall_alu !== 1'b1 || req_wb_valid !== 1'b0 || req_mm_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL respond_cycle: got stall %b wb_valid %b mm_valid %b, required 1 0 0",
                     stall_alu, req_wb_valid, req_mm_valid);
        end
        @(negedge clock);
        tests_run++;
        if (req_wb_valid !== 1'b1 || stall_alu !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL miss_wb: got wb_valid %b stall %b, required 1 0", req_wb_valid, stall_alu);
        end
        issue(1'b1, 1'b0, 1'b0, SIZE_WORD, 32'h100, 32'h0, 5'd5, 32'h2004, 32'hDEADBEEF, 1'b1, 1'b1);
        #1;
        tests_run++;
        if (stall_alu !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL hit_stall: got %b, required 0", stall_alu);
        end
        @(negedge clock);
        idle_req();
        tests_run++;
        if (req_wb_valid !== 1'b1 || req_mm_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL hit_latency: got wb_valid %b mm_valid %b, required 1 0", req_wb_valid, req_mm_valid);
        end
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 1'b0, 1'b1, SIZE_BYTE, 32'h103, 32'h0000_0055, 5'd0, 32'h3000, 32'h0, 1'b0, 1'b0);
        @(negedge clock);
        issue(1'b1, 1'b0, 1'b0, SIZE_WORD, 32'h100, 32'h0, 5'd6, 32'h3004, 32'h55ADBEEF, 1'b1, 1'b1);
        #1;
        tests_run++;
        if (stall_alu !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL store_load_stall: got %b, required 0", stall_alu);
        end
        @(negedge clock);
        issue(1'b1, 1'b0, 1'b0, SIZE_BYTE, 32'h103, 32'h0, 5'd8, 32'h3008, 32'h0000_0055, 1'b1, 1'b1);
        @(negedge clock);
        idle_req();
        @(negedge clock);
        tests_run++;
        if (req_wb_valid !== 1'b0 || req_mm_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_quiet: got wb_valid %b mm_valid %b, required 0 0", req_wb_valid, req_mm_valid);
        end
    endtask

    task automatic test_evict();
        logic [31:0]  a;
        logic         s;
        logic [127:0] d;
        logic         to;
        issue(1'b1, 1'b0, 1'b0, SIZE_WORD, 32'h140, 32'h0, 5'd9, 32'h4000, 32'hCAFEF00D, 1'b1, 1'b1);
        @(negedge clock);
        idle_req();
        mm_respond('0, a, s, d, to);
        tests_run++;
        if (to !== 1'b0 || a !== 32'h100 || s !== 1'b1 || d !== LINE_A_MERGED) begin
            tests_failed++;
            $display("[TB] FAIL evict_req: got timeout %b addr %h is_store %b data %h, required 0 00000100 1 %h",
                     to, a, s, d, LINE_A_MERGED);
        end
        tests_run++;
        if (stall_alu !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL evict_stall: got %b, required 1", stall_alu);
        end
        mm_respond(LINE_B, a, s, d, to);
        tests_run++;
        if (to !== 1'b0 || a !== 32'h140 || s !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL evict_refill_req: got timeout %b addr %h is_store %b, required 0 00000140 0", to, a, s);
        end
        tests_run++;
        if (stall_alu !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL refill_stall: got %b, required 1", stall_alu);
        end
        @(negedge clock);
        tests_run++;
        if (req_wb_valid !== 1'b1 || stall_alu !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL evict_wb: got wb_valid %b stall %b, required 1 0", req_wb_valid, stall_alu);
        end
    endtask

    task automatic test_misaligned();
        issue(1'b1, 1'b0, 1'b0, SIZE_WORD, 32'h102, 32'h0, 5'd10, 32'h5000, 32'h0, 1'b0, 1'b0);
        #1;
        tests_run++;
        if (stall_alu !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL xcpt_stall: got %b, required 0", stall_alu);
        end
        @(negedge clock);
        idle_req();
        tests_run++;
        if (xcpt_dcache_valid !== 1'b1 || xcpt_dcache_addr !== 32'h102 || req_mm_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL xcpt: got valid %b addr %h mm_valid %b, required 1 00000102 0",
                     xcpt_dcache_valid, xcpt_dcache_addr, req_mm_valid);
        end
        @(negedge clock);
        tests_run++;
        if (xcpt_dcache_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL xcpt_pulse: got %b, required 0", xcpt_dcache_valid);
        end
    endtask

    task automatic test_reset_mid_miss();
        logic [31:0]  a;
        logic         s;
        logic [127:0] d;
        logic         to;
        issue(1'b1, 1'b0, 1'b0, SIZE_WORD, 32'h100, 32'h0, 5'd11, 32'h6000, 32'h0, 1'b1, 1'b0);
        @(negedge clock);
        idle_req();
        tests_run++;
        if (req_mm_valid !== 1'b1 || req_mm_addr !== 32'h100 || req_mm_is_store !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL pre_reset_refill: got valid %b addr %h is_store %b, required 1 00000100 0",
                     req_mm_valid, req_mm_addr, req_mm_is_store);
        end
        reset = 1'b1;
        @(negedge clock);
        exp_q.delete();
        tests_run++;
        if (stall_alu !== 1'b0 || req_mm_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset: got stall %b mm_valid %b, required 0 0", stall_alu, req_mm_valid);
        end
        reset = 1'b0;
        @(negedge clock);
        issue(1'b1, 1'b0, 1'b0, SIZE_WORD, 32'h100, 32'h0, 5'd12, 32'h6004, 32'hDEADBEEF, 1'b1, 1'b1);
        #1;
        tests_run++;
        if (stall_alu !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_miss: got stall %b, required 1", stall_alu);
        end
        @(negedge clock);
        idle_req();
        mm_respond(LINE_A, a, s, d, to);
        tests_run++;
        if (to !== 1'b0 || a !== 32'h100 || s !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_refill: got timeout %b addr %h is_store %b, required 0 00000100 0", to, a, s);
        end
        repeat (2) @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_rtype_branch();
        test_load_miss();
        test_back_to_back();
        test_evict();
        test_misaligned();
        test_reset_mid_miss();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending write-backs, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
